hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline; it generates every select consumed by the B_, EX_ and MEM_ forward muxes, plus the stall/bubble controls.
- It keeps its own shadow pipeline of destination register, result source and Tnew for the E, M and W stages, advanced each clock.
- It compares decode-stage Tuse against producer Tnew to decide between forwarding and stalling.
- It sits beside the datapath; it does not touch data, only register numbers and control codes.

Parameters:
- PERF_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- D_rs  in  5  rs field of instruction in D.
- D_rt  in  5  rt field of instruction in D.
- D_tuse_rs  in  2  cycles until rs is needed (0 = branch/jr, 1 = ALU, 2 = store; 3 = not used).
- D_tuse_rt  in  2  same encoding, for rt.
- D_wreg  in  5  destination register after WriteRegMux select (0 = no write).
- D_res_src  in  2  00 ALU, 01 MEM, 10 PC8 (same codes as ResultToRegMux).
- stall  out  1  freeze PC and the IF/ID register.
- flush_E  out  1  clear the ID/EX register (insert bubble); equals stall.
- ForwardRSD  out  2  00 RData, 01 M_RData, 10 M_PC8.
- ForwardRTD  out  2  same encoding as ForwardRSD.
- ForwardRSE  out  2  00 RData, 01 W_RData, 10 M_RData, 11 M_PC8.
- ForwardRTE  out  2  same encoding as ForwardRSE.
- ForwardRTM  out  1  1 = RData2 (no forward), 0 = W_RData.
- stall_cnt  out  PERF_W  saturating count of stall cycles.

Behaviour:
- Shadow state: E_{rs,rt,wreg,src,tnew}, M_{rt,wreg,src,tnew}, W_{wreg,src}.
- Tnew at E entry: ALU = 1, MEM = 2, PC8 = 0.
- On every posedge: M gets E with tnew = max(E_tnew-1, 0); W gets M.
- E gets the D fields, or all-zero (bubble) when stall = 1.
- Reset (async, reset_n low): all shadow fields 0, stall_cnt 0.
- Outputs during and after reset: stall 0, flush_E 0, Forward*D/E 00, ForwardRTM 1.
- Match(reg, stage) requires reg != 0 and reg == stage_wreg. $0 never forwards and never stalls.
- Stall condition, evaluated for each D source s with tuse != 3:
  - stall if Match(s, E) and tuse < E_tnew;
  - stall if Match(s, E) and tuse == 0, because the D-stage path has no E-stage source;
  - stall if Match(s, M) and tuse < M_tnew.
- stall is the OR over rs and rt, purely combinational in the same cycle.
- D forwarding: Match(s, M) and M_tnew == 0 gives src PC8 → 10, ALU → 01. Otherwise 00.
- No W-stage forwarding at D: the GRF writes in the first half-cycle.
- E forwarding, M has priority over W:
  - Match(E_s, M) with M_src PC8 → 11; with M_src ALU → 10;
  - else Match(E_s, W) → 01;
  - else 00.
  - Match(E_s, M) with MEM src cannot occur (prevented by stall); if it does, fall through to the W check.
- M forwarding: Match(M_rt, W) → ForwardRTM 0, else 1.
- stall_cnt increments on each clock with stall = 1 and saturates at all-ones.
- Back-to-back stalls: E keeps receiving bubbles and D is held, so the same D fields are re-evaluated each cycle until the hazard clears.
- Reset asserted mid-stall: shadow state clears immediately and stall drops in the same cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - result-source codes RES_ALU / RES_MEM / RES_PC8;
  - Tuse constants TUSE_BR = 0, TUSE_ALU = 1, TUSE_ST = 2, TUSE_NONE = 3;
  - forward select constants for D, E and M.
- One sub-module, hfc_stage_reg: a resettable shadow-stage register with a bubble input. It is instantiated for E, M and W.

Test Plan:
- lw $8 followed by add $9,$8,$1 → stall = 1 for exactly 1 cycle. Next cycle ForwardRSE = 01 (W_RData). stall_cnt = 1.
- add $8 followed by beq $8,$0 → 1 stall cycle. Then ForwardRSD = 01 (M_RData) and ForwardRSE = 00.
- jal (wreg 31) followed by jr $31 → 1 stall while jal is in E. Then ForwardRSD = 10 (M_PC8).
- add $8, then sub $8, then or $10,$8,$8 → ForwardRSE = ForwardRTE = 10 (M wins over W). No stall.
- lw $8 followed by sw $8 → no stall. When sw reaches M, ForwardRTM = 0.
- Writes to $0 followed by reads of $0 → no stall, all forwards 00. Assert reset_n low mid-stall → stall = 0 immediately and ForwardRTM = 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared codes and helpers for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC8 = 2'b10;

   localparam logic [1:0] TUSE_BR   = 2'd0;
   localparam logic [1:0] TUSE_ALU  = 2'd1;
   localparam logic [1:0] TUSE_ST   = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] FWD_D_RDATA   = 2'b00;
   localparam logic [1:0] FWD_D_M_RDATA = 2'b01;
   localparam logic [1:0] FWD_D_M_PC8   = 2'b10;

   localparam logic [1:0] FWD_E_RDATA   = 2'b00;
   localparam logic [1:0] FWD_E_W_RDATA = 2'b01;
   localparam logic [1:0] FWD_E_M_RDATA = 2'b10;
   localparam logic [1:0] FWD_E_M_PC8   = 2'b11;

   localparam logic FWD_M_W_RDATA = 1'b0;
   localparam logic FWD_M_RDATA2  = 1'b1;

   // Shadow widths: E {rs,rt,wreg,src,tnew}, M {rt,wreg,src,tnew}, W {wreg}
   localparam int E_W = 19;
   localparam int M_W = 14;
   localparam int W_W = 5;

   function automatic logic reg_match(input logic [4:0] r, input logic [4:0] wreg);
      return (r != 5'd0) && (r == wreg);
   endfunction

   function automatic logic [1:0] tnew_at_entry(input logic [1:0] src);
      case (src)
         RES_MEM: return 2'd2;
         RES_PC8: return 2'd0;
         default: return 2'd1;
      endcase
   endfunction

   function automatic logic [1:0] dec_tnew(input logic [1:0] tnew);
      return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
   endfunction

endpackage

// File: rtl/hfc_stage_reg.sv
// One shadow pipeline stage: clears on reset or when a bubble is inserted.
module hfc_stage_reg #(
   parameter int W = 19
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_bubble,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_q <= '0;
      else if (i_bubble)
         r_q <= '0;
      else
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forward-select generation for the 5-stage pipeline,
// driven by a shadow copy of register numbers, result sources and Tnew.
module hazard_forward_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [4:0]        D_rs,
   input  logic [4:0]        D_rt,
   input  logic [1:0]        D_tuse_rs,
   input  logic [1:0]        D_tuse_rt,
   input  logic [4:0]        D_wreg,
   input  logic [1:0]        D_res_src,
   output logic              stall,
   output logic              flush_E,
   output logic [1:0]        ForwardRSD,
   output logic [1:0]        ForwardRTD,
   output logic [1:0]        ForwardRSE,
   output logic [1:0]        ForwardRTE,
   output logic              ForwardRTM,
   output logic [PERF_W-1:0] stall_cnt
);

   logic [E_W-1:0]    w_e_in, w_e_q;
   logic [M_W-1:0]    w_m_in, w_m_q;
   logic [W_W-1:0]    w_w_wreg;
   logic [4:0]        w_e_rs, w_e_rt, w_e_wreg, w_m_rt, w_m_wreg;
   logic [1:0]        w_e_src, w_e_tnew, w_m_src, w_m_tnew;
   logic              w_stall;
   logic [PERF_W-1:0] r_stall_cnt;

   assign w_e_in = {D_rs, D_rt, D_wreg, D_res_src, tnew_at_entry(D_res_src)};
   assign {w_e_rs, w_e_rt, w_e_wreg, w_e_src, w_e_tnew} = w_e_q;
   assign w_m_in = {w_e_rt, w_e_wreg, w_e_src, dec_tnew(w_e_tnew)};
   assign {w_m_rt, w_m_wreg, w_m_src, w_m_tnew} = w_m_q;

   hfc_stage_reg #(.W(E_W)) u_stage_e (
      .i_clk(clk), .i_rst_n(reset_n), .i_bubble(w_stall), .i_d(w_e_in), .o_q(w_e_q)
   );
   hfc_stage_reg #(.W(M_W)) u_stage_m (
      .i_clk(clk), .i_rst_n(reset_n), .i_bubble(1'b0), .i_d(w_m_in), .o_q(w_m_q)
   );
   hfc_stage_reg #(.W(W_W)) u_stage_w (
      .i_clk(clk), .i_rst_n(reset_n), .i_bubble(1'b0), .i_d(w_m_wreg), .o_q(w_w_wreg)
   );

   // The D-stage bypass has no E-stage source, so a branch-time use of an E result always waits.
   function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse);
      if (tuse == TUSE_NONE)
         return 1'b0;
      return (reg_match(s, w_e_wreg) && ((tuse < w_e_tnew) || (tuse == TUSE_BR))) ||
             (reg_match(s, w_m_wreg) && (tuse < w_m_tnew));
   endfunction

   function automatic logic [1:0] fwd_d(input logic [4:0] s);
      if (reg_match(s, w_m_wreg) && (w_m_tnew == 2'd0)) begin
         if (w_m_src == RES_PC8)
            return FWD_D_M_PC8;
         if (w_m_src == RES_ALU)
            return FWD_D_M_RDATA;
      end
      return FWD_D_RDATA;
   endfunction

   // A MEM-sourced match in M falls through to the W check.
   function automatic logic [1:0] fwd_e(input logic [4:0] s);
      if (reg_match(s, w_m_wreg) && (w_m_src == RES_PC8))
         return FWD_E_M_PC8;
      if (reg_match(s, w_m_wreg) && (w_m_src == RES_ALU))
         return FWD_E_M_RDATA;
      if (reg_match(s, w_w_wreg))
         return FWD_E_W_RDATA;
      return FWD_E_RDATA;
   endfunction

   assign w_stall    = src_stall(D_rs, D_tuse_rs) | src_stall(D_rt, D_tuse_rt);
   assign stall      = w_stall;
   assign flush_E    = w_stall;
   assign ForwardRSD = fwd_d(D_rs);
   assign ForwardRTD = fwd_d(D_rt);
   assign ForwardRSE = fwd_e(w_e_rs);
   assign ForwardRTE = fwd_e(w_e_rt);
   assign ForwardRTM = reg_match(w_m_rt, w_w_wreg) ? FWD_M_W_RDATA : FWD_M_RDATA2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != {PERF_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + PERF_W'(1);
   end

   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: each driven cycle queues its expected controls; a monitor checks them mid-cycle.
module tb_hazard_forward_ctrl;

   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [4:0]    D_rs, D_rt, D_wreg;
   logic [1:0]    D_tuse_rs, D_tuse_rt, D_res_src;
   logic          stall, flush_E, ForwardRTM;
   logic [1:0]    ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;
   logic [PW-1:0] stall_cnt;

   typedef struct packed {
      logic          st;
      logic          fl;
      logic [1:0]    rsd;
      logic [1:0]    rtd;
      logic [1:0]    rse;
      logic [1:0]    rte;
      logic          rtm;
      logic [PW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   idx_q[$];
   int   checks = 0;
   int   failures = 0;
   int   vec_no = 0;

   hazard_forward_ctrl #(.PERF_W(PW)) dut (
      .clk(clk), .reset_n(reset_n),
      .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
      .D_wreg(D_wreg), .D_res_src(D_res_src),
      .stall(stall), .flush_E(flush_E),
      .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD),
      .ForwardRSE(ForwardRSE), .ForwardRTE(ForwardRTE),
      .ForwardRTM(ForwardRTM), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // One pipeline cycle: drive D fields just after the edge and queue what should be seen.
   task automatic vec(input logic rn,
                      input int rs, input int rt, input int tr, input int tt, input int wr, input int src,
                      input logic st, input int rsd, input int rtd, input int rse, input int rte,
                      input logic rtm, input int cnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n   = rn;
      D_rs      = 5'(rs);
      D_rt      = 5'(rt);
      D_tuse_rs = 2'(tr);
      D_tuse_rt = 2'(tt);
      D_wreg    = 5'(wr);
      D_res_src = 2'(src);
      e.st  = st;
      e.fl  = st;
      e.rsd = 2'(rsd);
      e.rtd = 2'(rtd);
      e.rse = 2'(rse);
      e.rte = 2'(rte);
      e.rtm = rtm;
      e.cnt = PW'(cnt);
      exp_q.push_back(e);
      idx_q.push_back(vec_no);
      vec_no++;
   endtask

   always @(negedge clk) begin
      exp_t a, e;
      int   n;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n = idx_q.pop_front();
         a = {stall, flush_E, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM, stall_cnt};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL vec%0d {stall,flushE,RSD,RTD,RSE,RTE,RTM,cnt} got %b_%b_%b_%b_%b_%b_%b_%0d want %b_%b_%b_%b_%b_%b_%b_%0d",
                     n, a.st, a.fl, a.rsd, a.rtd, a.rse, a.rte, a.rtm, a.cnt,
                     e.st, e.fl, e.rsd, e.rtd, e.rse, e.rte, e.rtm, e.cnt);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      D_rs = '0; D_rt = '0; D_wreg = '0;
      D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_res_src = '0;

      // reset: hazard-looking D fields must not produce stalls or forwards
      vec(0, 8,8,0,0,8,1,  0,0,0,0,0,1,0);
      vec(0, 8,8,0,0,8,1,  0,0,0,0,0,1,0);
      // lw $8 ; add $9,$8,$1
      vec(1, 2,8,1,3,8,1,  0,0,0,0,0,1,0);
      vec(1, 8,1,1,1,9,0,  1,0,0,0,0,1,0);
      vec(1, 8,1,1,1,9,0,  0,0,0,0,0,1,1);
      vec(1, 0,0,3,3,0,0,  0,0,0,1,0,1,1);
      vec(1, 0,0,3,3,0,0,  0,0,0,0,0,1,1);
      // add $8 ; beq $8,$0
      vec(1, 1,2,1,1,8,0,  0,0,0,0,0,1,1);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,1);
      vec(1, 8,0,0,0,0,0,  0,1,0,0,0,1,2);
      // jal ; jr $31
      vec(1, 0,0,3,3,31,2, 0,0,0,1,0,1,2);
      vec(1, 31,0,0,3,0,0, 1,0,0,0,0,1,2);
      vec(1, 31,0,0,3,0,0, 0,2,0,0,0,1,3);
      // add $8 ; sub $8 ; or $10,$8,$8
      vec(1, 1,2,1,1,8,0,  0,0,0,1,0,1,3);
      vec(1, 3,4,1,1,8,0,  0,0,0,0,0,1,3);
      vec(1, 8,8,1,1,10,0, 0,1,1,0,0,1,3);
      vec(1, 0,0,3,3,0,0,  0,0,0,2,2,1,3);
      // lw $8 ; sw $8
      vec(1, 2,8,1,3,8,1,  0,0,0,0,0,0,3);
      vec(1, 2,8,1,2,0,0,  0,0,0,0,0,1,3);
      vec(1, 0,0,3,3,0,0,  0,0,0,0,0,1,3);
      vec(1, 0,0,3,3,0,0,  0,0,0,0,0,0,3);
      // writes to $0 then reads of $0
      vec(1, 1,0,1,3,0,0,  0,0,0,0,0,1,3);
      vec(1, 0,0,0,0,0,0,  0,0,0,0,0,1,3);
      vec(1, 0,0,1,3,0,1,  0,0,0,0,0,1,3);
      vec(1, 0,0,1,1,0,0,  0,0,0,0,0,1,3);
      // lw $8 ; beq $8: two back-to-back stalls
      vec(1, 2,8,1,3,8,1,  0,0,0,0,0,1,3);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,3);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,4);
      vec(1, 8,0,0,0,0,0,  0,0,0,0,0,1,5);
      vec(1, 2,8,1,3,8,1,  0,0,0,0,0,1,5);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,5);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,6);
      vec(1, 8,0,0,0,0,0,  0,0,0,0,0,1,7);
      // counter saturates at all-ones
      vec(1, 2,8,1,3,8,1,  0,0,0,0,0,1,7);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,7);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,7);
      vec(1, 8,0,0,0,0,0,  0,0,0,0,0,1,7);
      vec(1, 2,8,1,3,8,1,  0,0,0,0,0,1,7);
      vec(1, 8,0,0,0,0,0,  1,0,0,0,0,1,7);
      // reset lands while the second stall cycle is pending
      vec(0, 8,0,0,0,0,0,  0,0,0,0,0,1,0);
      vec(0, 8,0,0,0,0,0,  0,0,0,0,0,1,0);
      vec(1, 8,0,0,0,0,0,  0,0,0,0,0,1,0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++)
         @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
